// File: rtl/store_buffer.sv
// Posted-write buffer in front of DataMemory port 1: in-order store FIFO, one-entry
// output register driving the write port, and a combinational load-vs-store hazard check.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 10
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 1024
`endif
`ifndef STORE_BYTE
`define STORE_BYTE 4'h1
`endif
`ifndef STORE_HALFWORD
`define STORE_HALFWORD 4'h2
`endif
`ifndef STORE_WORD
`define STORE_WORD 4'h3
`endif
`ifndef STORE_DOUBLEWORD
`define STORE_DOUBLEWORD 4'h4
`endif
`ifndef LOAD_BYTE
`define LOAD_BYTE 4'h1
`endif
`ifndef LOAD_HALFWORD
`define LOAD_HALFWORD 4'h2
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 4'h3
`endif
`ifndef LOAD_DOUBLEWORD
`define LOAD_DOUBLEWORD 4'h4
`endif
`ifndef LOAD_BYTE_UNSIGNED
`define LOAD_BYTE_UNSIGNED 4'h5
`endif
`ifndef LOAD_HALFWORD_UNSIGNED
`define LOAD_HALFWORD_UNSIGNED 4'h6
`endif

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clock_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [`BIT_WIDTH-1:0]   st_addr_i,
  input  logic [`BIT_WIDTH-1:0]   st_data_i,
  input  logic [3:0]              st_type_i,
  input  logic                    ld_valid_i,
  input  logic [`BIT_WIDTH-1:0]   ld_addr_i,
  input  logic [3:0]              ld_type_i,
  output logic                    ld_hazard_o,
  input  logic                    mem_port_busy_i,
  output logic                    mem_wr_en_o,
  output logic [`BIT_WIDTH-1:0]   mem_addr_o,
  output logic [`BIT_WIDTH-1:0]   mem_data_o,
  output logic [3:0]              mem_storetype_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MB = `MEMORY_BITS;

  function automatic logic [3:0] st_size(input logic [3:0] t);
    case (t)
      `STORE_BYTE:       st_size = 4'd1;
      `STORE_HALFWORD:   st_size = 4'd2;
      `STORE_WORD:       st_size = 4'd4;
      `STORE_DOUBLEWORD: st_size = 4'd8;
      default:           st_size = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] ld_size(input logic [3:0] t);
    case (t)
      `LOAD_BYTE, `LOAD_BYTE_UNSIGNED:         ld_size = 4'd1;
      `LOAD_HALFWORD, `LOAD_HALFWORD_UNSIGNED: ld_size = 4'd2;
      `LOAD_WORD:                              ld_size = 4'd4;
      `LOAD_DOUBLEWORD:                        ld_size = 4'd8;
      default:                                 ld_size = 4'd0;
    endcase
  endfunction

  // One extra address bit keeps a+size from wrapping at the top of memory.
  function automatic logic overlaps(input logic [`BIT_WIDTH-1:0] sa, input logic [3:0] ss,
                                    input logic [`BIT_WIDTH-1:0] la, input logic [3:0] ls);
    logic [MB:0] a;
    logic [MB:0] b;
    a = {1'b0, sa[MB-1:0]};
    b = {1'b0, la[MB-1:0]};
    overlaps = (ls != 4'd0) && (ss != 4'd0) &&
               (a < b + {{(MB-3){1'b0}}, ls}) && (b < a + {{(MB-3){1'b0}}, ss});
  endfunction

  logic [`BIT_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [`BIT_WIDTH-1:0] data_mem_q [DEPTH];
  logic [3:0]            type_mem_q [DEPTH];

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en_q, wr_en_d;
  logic [`BIT_WIDTH-1:0] out_addr_q, out_addr_d, out_data_q, out_data_d;
  logic [3:0]            out_type_q, out_type_d;
  logic                  full_s, push_s, pop_s, hit_s;
  logic [PW-1:0]         offset_s;

  assign full_s          = (count_q == CW'(DEPTH));
  assign st_ready_o      = !full_s;
  assign full_o          = full_s;
  assign count_o         = count_q;
  assign empty_o         = (count_q == {CW{1'b0}}) && !wr_en_q;
  assign mem_wr_en_o     = wr_en_q;
  assign mem_addr_o      = out_addr_q;
  assign mem_data_o      = out_data_q;
  assign mem_storetype_o = out_type_q;

  always_comb begin
    push_s     = st_valid_i && !full_s && (st_size(st_type_i) != 4'd0);
    pop_s      = (count_q != {CW{1'b0}}) && !mem_port_busy_i;
    head_d     = head_q;
    tail_d     = tail_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_type_d = out_type_q;
    wr_en_d    = pop_s;
    count_d    = count_q + CW'(push_s) - CW'(pop_s);
    if (push_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d     = head_q + PW'(1);
      out_addr_d = addr_mem_q[head_q];
      out_data_d = data_mem_q[head_q];
      out_type_d = type_mem_q[head_q];
    end else begin
      head_d = head_q;
    end
  end

  // Entries between head and head+count are live; the output register counts while it is writing.
  always_comb begin
    hit_s    = wr_en_q && overlaps(out_addr_q, st_size(out_type_q), ld_addr_i, ld_size(ld_type_i));
    offset_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset_s = PW'(i) - head_q;
      if (({1'b0, offset_s} < count_q) &&
          overlaps(addr_mem_q[i], st_size(type_mem_q[i]), ld_addr_i, ld_size(ld_type_i))) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    ld_hazard_o = ld_valid_i && hit_s;
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      wr_en_q    <= 1'b0;
      out_addr_q <= {`BIT_WIDTH{1'b0}};
      out_data_q <= {`BIT_WIDTH{1'b0}};
      out_type_q <= 4'd0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_type_q <= out_type_d;
    end
  end

  // Storage needs no reset: liveness comes only from head/count.
  always_ff @(posedge clock_i) begin
    if (push_s) begin
      addr_mem_q[tail_q] <= st_addr_i;
      data_mem_q[tail_q] <= st_data_i;
      type_mem_q[tail_q] <= st_type_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed stores/loads, scoreboard-checked drain stream.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 10
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 1024
`endif
`ifndef STORE_BYTE
`define STORE_BYTE 4'h1
`endif
`ifndef STORE_HALFWORD
`define STORE_HALFWORD 4'h2
`endif
`ifndef STORE_WORD
`define STORE_WORD 4'h3
`endif
`ifndef STORE_DOUBLEWORD
`define STORE_DOUBLEWORD 4'h4
`endif
`ifndef LOAD_BYTE
`define LOAD_BYTE 4'h1
`endif
`ifndef LOAD_HALFWORD
`define LOAD_HALFWORD 4'h2
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 4'h3
`endif
`ifndef LOAD_DOUBLEWORD
`define LOAD_DOUBLEWORD 4'h4
`endif
`ifndef LOAD_BYTE_UNSIGNED
`define LOAD_BYTE_UNSIGNED 4'h5
`endif
`ifndef LOAD_HALFWORD_UNSIGNED
`define LOAD_HALFWORD_UNSIGNED 4'h6
`endif

module tb_store_buffer;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0, st_ready;
  logic [63:0] st_addr = 64'd0, st_data = 64'd0;
  logic [3:0]  st_type = 4'd0;
  logic        ld_valid = 1'b0;
  logic [63:0] ld_addr = 64'd0;
  logic [3:0]  ld_type = 4'd0;
  logic        ld_hazard;
  logic        mem_port_busy = 1'b0;
  logic        mem_wr_en;
  logic [63:0] mem_addr, mem_data;
  logic [3:0]  mem_storetype;
  logic [2:0]  count;
  logic        empty, full;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [3:0]  t;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int passes = 0;
  logic [7:0] bmem [0:1023];
  logic wrap_done = 1'b0;

  store_buffer #(.DEPTH(4)) dut (
    .clock_i(clock), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_data_i(st_data), .st_type_i(st_type),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_type_i(ld_type),
    .ld_hazard_o(ld_hazard), .mem_port_busy_i(mem_port_busy),
    .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_storetype_o(mem_storetype), .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clock = ~clock;

  function automatic int st_sz(input logic [3:0] t);
    case (t)
      `STORE_BYTE:       return 1;
      `STORE_HALFWORD:   return 2;
      `STORE_WORD:       return 4;
      `STORE_DOUBLEWORD: return 8;
      default:           return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected store.
  always @(negedge clock) begin
    if (!rst && mem_wr_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%h type=%h", mem_addr, mem_data, mem_storetype);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (mem_addr === e.a && mem_data === e.d && mem_storetype === e.t) passes++;
        else $display("FAIL drain_order actual=%h/%h/%h expected=%h/%h/%h",
                      mem_addr, mem_data, mem_storetype, e.a, e.d, e.t);
        for (int k = 0; k < st_sz(mem_storetype); k++)
          bmem[(int'(mem_addr[9:0]) + k) % 1024] = mem_data[8*k +: 8];
      end
    end
  end

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] t);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
    while (!st_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!st_ready) begin
      chk("store_accept_timeout", 64'(st_ready), 64'd1);
    end else if (st_sz(t) != 0) begin
      e.a = a; e.d = d; e.t = t;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1 st_valid = 1'b0;
  endtask

  task automatic ld_chk(input string name, input logic [63:0] a, input logic [3:0] t,
                        input logic v, input logic exp);
    @(negedge clock);
    ld_valid = v; ld_addr = a; ld_type = t;
    #1 chk(name, 64'(ld_hazard), 64'(exp));
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(name, 64'(empty), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
    ld_valid = 1'b1; ld_addr = 64'h0; ld_type = `LOAD_WORD;
    #12;
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_hazard", 64'(ld_hazard), 64'd0);
    ld_valid = 1'b0;
    @(negedge clock) rst = 1'b0;

    // Basic drain: back-to-back write pulses.
    do_store(64'h10, 64'h1122334455667788, `STORE_DOUBLEWORD);
    do_store(64'h20, 64'h00000000DEADBEEF, `STORE_WORD);
    @(negedge clock);
    chk("drain1_wr_en", 64'(mem_wr_en), 64'd1);
    chk("drain1_addr", mem_addr, 64'h10);
    @(negedge clock);
    chk("drain2_wr_en", 64'(mem_wr_en), 64'd1);
    chk("drain2_addr", mem_addr, 64'h20);
    @(negedge clock);
    chk("drain_idle_wr_en", 64'(mem_wr_en), 64'd0);
    chk("drain_idle_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 8; i++) chk("mem_sd_byte", 64'(bmem[16 + i]), 64'(8'h88 - 8'(8'h11 * i)));
    chk("mem_sw_b0", 64'(bmem[32]), 64'hEF);
    chk("mem_sw_b1", 64'(bmem[33]), 64'hBE);
    chk("mem_sw_b2", 64'(bmem[34]), 64'hAD);
    chk("mem_sw_b3", 64'(bmem[35]), 64'hDE);

    // Full / backpressure.
    mem_port_busy = 1'b1;
    for (int i = 0; i < 4; i++) do_store(64'h100 + 64'(8 * i), 64'hA5A5_0000 + 64'(i), `STORE_DOUBLEWORD);
    @(negedge clock);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_st_ready", 64'(st_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    fork
      do_store(64'h120, 64'hA5A5_0004, `STORE_DOUBLEWORD);
      begin
        repeat (3) @(negedge clock);
        chk("held_st_ready", 64'(st_ready), 64'd0);
        mem_port_busy = 1'b0;
      end
    join
    wait_empty("full_drain_empty");

    // Hazard boundaries against a pending SW @0x20.
    mem_port_busy = 1'b1;
    do_store(64'h20, 64'hCAFEF00D, `STORE_WORD);
    ld_chk("hz_lb_23", 64'h23, `LOAD_BYTE, 1'b1, 1'b1);
    ld_chk("hz_lb_24", 64'h24, `LOAD_BYTE, 1'b1, 1'b0);
    ld_chk("hz_ld_1c", 64'h1C, `LOAD_DOUBLEWORD, 1'b1, 1'b1);
    ld_chk("hz_lh_1e", 64'h1E, `LOAD_HALFWORD, 1'b1, 1'b0);
    ld_chk("hz_lbu_20", 64'h20, `LOAD_BYTE_UNSIGNED, 1'b1, 1'b1);
    ld_chk("hz_bad_type", 64'h20, 4'hF, 1'b1, 1'b0);
    ld_chk("hz_no_valid", 64'h20, `LOAD_WORD, 1'b0, 1'b0);
    @(negedge clock);
    mem_port_busy = 1'b0;
    ld_valid = 1'b1; ld_addr = 64'h20; ld_type = `LOAD_WORD;
    #1 chk("hz_lw_pending", 64'(ld_hazard), 64'd1);
    @(negedge clock);
    chk("hz_lw_inflight_wr", 64'(mem_wr_en), 64'd1);
    chk("hz_lw_inflight", 64'(ld_hazard), 64'd1);
    @(negedge clock);
    chk("hz_lw_landed", 64'(ld_hazard), 64'd0);
    ld_valid = 1'b0;

    // Wrap-around with alternating port usage.
    fork
      begin
        for (int i = 0; i < 10; i++) do_store(64'h200 + 64'(4 * i), 64'hB000 + 64'(i), `STORE_WORD);
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          @(negedge clock);
          mem_port_busy = ~mem_port_busy;
        end
        mem_port_busy = 1'b0;
      end
    join
    wait_empty("wrap_empty");
    chk("wrap_count", 64'(count), 64'd0);

    // Illegal type and top of memory.
    mem_port_busy = 1'b1;
    do_store(64'h300, 64'h5A, `STORE_BYTE);
    do_store(64'h308, 64'h77, 4'hF);
    @(negedge clock);
    chk("illegal_count", 64'(count), 64'd1);
    do_store(64'(`MEMORY_SIZE - 8), 64'h0102030405060708, `STORE_DOUBLEWORD);
    ld_chk("top_lb_last", 64'(`MEMORY_SIZE - 1), `LOAD_BYTE, 1'b1, 1'b1);
    ld_chk("top_lb_below", 64'(`MEMORY_SIZE - 9), `LOAD_BYTE, 1'b1, 1'b0);
    ld_chk("sb_lb_hit", 64'h300, `LOAD_BYTE, 1'b1, 1'b1);
    ld_chk("illegal_not_stored", 64'h308, `LOAD_BYTE, 1'b1, 1'b0);
    mem_port_busy = 1'b0;
    wait_empty("top_drain_empty");

    // Reset in the middle of a drain.
    mem_port_busy = 1'b1;
    for (int i = 0; i < 4; i++) do_store(64'h400 + 64'(4 * i), 64'hC000 + 64'(i), `STORE_WORD);
    @(negedge clock) mem_port_busy = 1'b0;
    @(posedge clock);
    #2;
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_wr_en", 64'(mem_wr_en), 64'd1);
    rst = 1'b1;
    sb_q.delete();
    ld_valid = 1'b1; ld_addr = 64'h404; ld_type = `LOAD_WORD;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("mid_rst_st_ready", 64'(st_ready), 64'd1);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_full", 64'(full), 64'd0);
    chk("mid_rst_hazard", 64'(ld_hazard), 64'd0);
    ld_valid = 1'b0;
    @(negedge clock) rst = 1'b0;
    repeat (6) @(negedge clock);
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline's memory stage and DataMemory port 1. Stores are accepted into a small in-order FIFO and drained into the memory's write port whenever the pipeline is not using that port for a load. Younger loads are checked against every pending store, including the one in flight to memory, and a hazard is flagged so the pipeline stalls until the conflicting store has landed.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clock  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the memory stage.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  `BIT_WIDTH  store byte address.
- st_data  in  `BIT_WIDTH  store data, little-endian, low bytes used.
- st_type  in  4  store type: `STORE_BYTE, `STORE_HALFWORD, `STORE_WORD or `STORE_DOUBLEWORD.
- ld_valid  in  1  load being issued this cycle; its address is checked.
- ld_addr  in  `BIT_WIDTH  load byte address.
- ld_type  in  4  `LOAD_* type.
- ld_hazard  out  1  combinational; the load overlaps a pending store.
- mem_port_busy  in  1  memory port 1 is used by a load this cycle; no drain.
- mem_wr_en  out  1  drives MemWriteEn1.
- mem_addr  out  `BIT_WIDTH  drives AddressBus1 while mem_wr_en is high.
- mem_data  out  `BIT_WIDTH  drives DataMemoryInput1.
- mem_storetype  out  4  drives storetype1.
- count  out  $clog2(DEPTH)+1  number of FIFO entries; excludes the output register.
- empty  out  1  count==0 and mem_wr_en==0, so all stores are committed.
- full  out  1  count==DEPTH.

## Operation
- **FIFO storage:** head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH. count is kept separately.
- **Enqueue:**
  - st_ready = !full.
  - On st_valid && st_ready with a legal st_type, {addr, data, type} is written at the tail.
  - st_valid with an illegal st_type is dropped silently; count is unchanged.
- **Drain:**
  - Each cycle, if count>0 and !mem_port_busy, the head entry is loaded into the output register and popped, and mem_wr_en←1.
  - Otherwise mem_wr_en←0, and mem_addr/data/storetype hold their last value.
  - At most one entry drains per cycle. Order is strictly FIFO.
- **Simultaneous enqueue and drain:** count is unchanged. When full, st_ready is already low; there is no same-cycle pass-through.
- **Access sizes:** byte=1, halfword=2, word=4, doubleword=8. Loads: LB/LBU=1, LH/LHU=2, LW=4, LD=8. Any other ld_type has size 0 and never causes a hazard.
- **Hazard check:**
  - Only the low `MEMORY_BITS address bits are used, zero-extended to `MEMORY_BITS+1 bits so that end addresses do not wrap.
  - A load range [b, b+ls) overlaps an entry range [a, a+s) if a < b+ls and b < a+s.
  - ld_hazard = ld_valid && (overlap with any valid FIFO entry, or with the output register while mem_wr_en=1).
  - The check is purely combinational on the current state. A store enqueued in the same cycle is not included; the pipeline guarantees a store and a load never issue in the same cycle.
- **Reset (asynchronous, any time):**
  - Pointers, count and mem_wr_en are cleared to 0; mem_addr, mem_data and mem_storetype are cleared to 0.
  - Pending stores are discarded, including one in the output register.
  - After reset: st_ready=1, empty=1, full=0, ld_hazard=0.

## Timing
- Store accepted at edge N is at the FIFO head after edge N.
- With an empty FIFO and mem_port_busy=0, mem_wr_en goes high after edge N+1, and DataMemory writes the data at edge N+2.
- Drain throughput is 1 store/cycle while mem_port_busy=0. mem_port_busy=1 inserts bubbles; every entry is kept.
- ld_hazard has zero latency: it is valid in the same cycle as ld_valid/ld_addr/ld_type. It drops in the cycle after the overlapping store's mem_wr_en pulse.
- full, count and st_ready change only on posedge or async reset.

## Test plan
- **Reset:** assert rst mid-drain with count=3 → immediately count=0, mem_wr_en=0, st_ready=1, empty=1. No further write pulses after release.
- **Basic drain:** SD 0x1122334455667788 @0x10, then SW 0xDEADBEEF @0x20, mem_port_busy=0 → mem_wr_en pulses on two consecutive cycles with (0x10, SD) then (0x20, SW). Memory bytes 0x10..0x17 = 88..11 and 0x20..0x23 = EF,BE,AD,DE.
- **Full / backpressure:** hold mem_port_busy=1 and push 5 stores with DEPTH=4 → st_ready=0 after the 4th and full=1. The 5th store is held until busy drops, then all 5 drain in order.
- **Hazard boundaries:** pending SW @0x20, with mem_port_busy=1 so it stays pending.
  - LB @0x23 → ld_hazard=1.
  - LB @0x24 → 0.
  - LD @0x1C → 1.
  - LH @0x1E → 0.
  - Release busy; LW @0x20 → ld_hazard stays 1 during the mem_wr_en cycle and becomes 0 the next cycle.
- **Wrap-around:** stream 10 stores with alternating mem_port_busy → pointers wrap twice, the write order matches issue order, and count returns to 0 with empty=1.
- **Illegal type / top of memory:** st_type=4'hF → not enqueued, count unchanged. SD @`MEMORY_SIZE-8 with LB @`MEMORY_SIZE-1 → hazard=1, and the range check does not overflow.
